// File: rtl/an_sched_pkg.sv
// Shared constants, FSM state type and cell geometry helpers for the 6x6 AN
// decoder scheduler.
package an_sched_pkg;

   localparam int GRID    = 6;
   localparam int N_CELLS = 36;
   localparam int Q_W     = 3;
   localparam int R_W     = 4;
   localparam int IDX_W   = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic int cell_row(input int k);
      return k / GRID;
   endfunction

   function automatic int cell_col(input int k);
      return k % GRID;
   endfunction

   // A cell is a candidate when both its row and its column carry a flag.
   function automatic logic [N_CELLS-1:0] cand_mask(input logic [N_CELLS-1:0] err);
      logic [GRID-1:0]    er;
      logic [GRID-1:0]    ec;
      logic [N_CELLS-1:0] m;
      er = {GRID{1'b0}};
      ec = {GRID{1'b0}};
      m  = {N_CELLS{1'b0}};
      for (int k = 0; k < N_CELLS; k++) begin
         er[cell_row(k)] = er[cell_row(k)] | err[k];
         ec[cell_col(k)] = ec[cell_col(k)] | err[k];
      end
      for (int k = 0; k < N_CELLS; k++) begin
         m[k] = er[cell_row(k)] & ec[cell_col(k)];
      end
      return m;
   endfunction

endpackage

// File: rtl/an_sched_pick.sv
// Lowest-set-bit priority encoder over the 36 candidate cells.
module an_sched_pick
   import an_sched_pkg::*;
(
   input  logic [N_CELLS-1:0] req_i,
   output logic [IDX_W-1:0]   idx_o,
   output logic               any_o
);

   // Scan from the top so the lowest set bit is the last one to win.
   always_comb begin
      idx_o = {IDX_W{1'b0}};
      for (int k = N_CELLS - 1; k >= 0; k--) begin
         idx_o = req_i[k] ? IDX_W'(k) : idx_o;
      end
      any_o = |req_i;
   end

endmodule

// File: rtl/an_sched_6x6.sv
// Schedules the shared AN decoder over flagged cells of a 6x6 Barrett block.
// Define AN_SCHED_DIRECT_EN to decode exactly the flagged cells instead of the row/column intersection.
module an_sched_6x6
   import an_sched_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N_CELLS-1:0]       err_flags,
   input  logic [N_CELLS*Q_W-1:0]   q_bus,
   input  logic [N_CELLS*R_W-1:0]   r_bus,
   output logic [Q_W-1:0]           dec_quotient,
   output logic [R_W-1:0]           dec_residue,
   input  logic [Q_W-1:0]           dec_message,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N_CELLS*Q_W-1:0]   out_data,
   output logic [5:0]               corr_count
);

   localparam logic [N_CELLS-1:0] ONE_LSB = {{(N_CELLS-1){1'b0}}, 1'b1};

   state_e                   state_q, state_d;
   logic [N_CELLS*Q_W-1:0]   q_q, q_d;
   logic [N_CELLS*R_W-1:0]   r_q, r_d;
   logic [N_CELLS-1:0]       mask_q, mask_d;
   logic [5:0]               cnt_q, cnt_d;
   logic [N_CELLS-1:0]       cand_s;
   logic [N_CELLS-1:0]       rest_s;
   logic [IDX_W-1:0]         sel_s;
   logic                     any_s;
   logic                     hs_s;

`ifdef AN_SCHED_DIRECT_EN
   assign cand_s = err_flags;
`else
   assign cand_s = cand_mask(err_flags);
`endif

   an_sched_pick u_pick (
      .req_i (mask_q),
      .idx_o (sel_s),
      .any_o (any_s)
   );

   assign hs_s   = in_valid & (state_q == ST_IDLE);
   assign rest_s = mask_q & ~(ONE_LSB << sel_s);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = (|cand_s) ? ST_SCAN : ST_DONE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (!any_s || (rest_s == {N_CELLS{1'b0}})) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_SCAN;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs; decoder operands come from the captured slot being repaired.
   always_comb begin
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      dec_quotient = {Q_W{1'b0}};
      dec_residue  = {R_W{1'b0}};
      case (state_q)
         ST_IDLE: in_ready = 1'b1;
         ST_SCAN: begin
            dec_quotient = q_q[Q_W*sel_s +: Q_W];
            dec_residue  = r_q[R_W*sel_s +: R_W];
         end
         ST_DONE: out_valid = 1'b1;
         default: in_ready = 1'b0;
      endcase
   end

   // Block capture and in-place correction of one cell per SCAN cycle.
   always_comb begin
      q_d    = q_q;
      r_d    = r_q;
      mask_d = mask_q;
      cnt_d  = cnt_q;
      if (hs_s) begin
         q_d    = q_bus;
         r_d    = r_bus;
         mask_d = cand_s;
         cnt_d  = 6'd0;
      end else if ((state_q == ST_SCAN) && any_s) begin
         q_d[Q_W*sel_s +: Q_W] = dec_message;
         mask_d[sel_s]         = 1'b0;
         cnt_d                 = cnt_q + 6'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q    <= {(N_CELLS*Q_W){1'b0}};
         r_q    <= {(N_CELLS*R_W){1'b0}};
         mask_q <= {N_CELLS{1'b0}};
         cnt_q  <= 6'd0;
      end else begin
         q_q    <= q_d;
         r_q    <= r_d;
         mask_q <= mask_d;
         cnt_q  <= cnt_d;
      end
   end

   assign out_data   = q_q;
   assign corr_count = cnt_q;

endmodule

// File: tb/tb_an_sched_6x6.sv
// Directed scoreboard bench for an_sched_6x6 with a behavioural stand-in for the shared decoder.
module tb_an_sched_6x6;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [35:0]    err_flags;
   logic [107:0]   q_bus;
   logic [143:0]   r_bus;
   logic [2:0]     dec_quotient;
   logic [3:0]     dec_residue;
   logic [2:0]     dec_message;
   logic           out_valid;
   logic           out_ready;
   logic [107:0]   out_data;
   logic [5:0]     corr_count;

   int             n_vec  = 0;
   int             n_fail = 0;
   logic           fixed_mode;
   int             cur_k;
   int             obs_cnt;
   int             lat;
   logic [107:0]   cur_q;
   logic [143:0]   cur_r;

   typedef struct {
      logic [107:0] data;
      logic [5:0]   cnt;
   } exp_t;

   exp_t exp_q[$];
   int   cell_q[$];

   an_sched_6x6 dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .err_flags    (err_flags),
      .q_bus        (q_bus),
      .r_bus        (r_bus),
      .dec_quotient (dec_quotient),
      .dec_residue  (dec_residue),
      .dec_message  (dec_message),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .corr_count   (corr_count)
   );

   always #5 clk = ~clk;

   always_comb begin
      dec_message = fixed_mode ? 3'd5 : (dec_quotient ^ dec_residue[2:0] ^ 3'd1);
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [35:0] model_mask(input logic [35:0] e);
      logic [5:0]  er;
      logic [5:0]  ec;
      logic [35:0] m;
      er = 6'd0;
      ec = 6'd0;
      m  = 36'd0;
`ifdef AN_SCHED_DIRECT_EN
      m = e;
`else
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < 6; j++) begin
            if (e[i*6+j]) begin
               er[i] = 1'b1;
               ec[j] = 1'b1;
            end
         end
      end
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < 6; j++) begin
            m[i*6+j] = er[i] & ec[j];
         end
      end
`endif
      return m;
   endfunction

   task automatic apply(input logic [35:0] e, input logic [107:0] q, input logic [143:0] r);
      logic [35:0] m;
      exp_t        x;
      m      = model_mask(e);
      x.data = q;
      x.cnt  = 6'd0;
      cur_k  = 0;
      for (int k = 0; k < 36; k++) begin
         if (m[k]) begin
            cell_q.push_back(k);
            x.data[3*k +: 3] = fixed_mode ? 3'd5 : (q[3*k +: 3] ^ r[4*k +: 3] ^ 3'd1);
            x.cnt = x.cnt + 6'd1;
            cur_k++;
         end
      end
      exp_q.push_back(x);
      cur_q = q;
      cur_r = r;
      @(negedge clk);
      chk("in_ready_before_accept", in_ready, 1);
      in_valid  = 1'b1;
      err_flags = e;
      q_bus     = q;
      r_bus     = r;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      err_flags = 36'hF_FFFF_FFFF;
      q_bus     = ~q;
      r_bus     = ~r;
   endtask

   task automatic scan_cell();
      int c;
      chk("pending_cells", (cell_q.size() > 0), 1);
      if (cell_q.size() > 0) begin
         c = cell_q.pop_front();
         chk("dec_quotient", dec_quotient, cur_q[3*c +: 3]);
         chk("dec_residue", dec_residue, cur_r[4*c +: 4]);
         chk("in_ready_scan", in_ready, 0);
      end
   endtask

   task automatic drain(input int hold);
      exp_t x;
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 60) begin
         scan_cell();
         lat++;
         @(negedge clk);
      end
      chk("out_valid_rise", out_valid, 1);
      chk("latency_scan_cycles", lat, cur_k);
      chk("cells_left", cell_q.size(), 0);
      chk("exp_available", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         chk("out_data", out_data, x.data);
         chk("corr_count", corr_count, x.cnt);
         chk("dec_q_idle_done", dec_quotient, 0);
         chk("dec_r_idle_done", dec_residue, 0);
         chk("in_ready_done", in_ready, 0);
         for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            @(negedge clk);
            chk("out_valid_hold", out_valid, 1);
            chk("out_data_hold", out_data, x.data);
            chk("corr_count_hold", corr_count, x.cnt);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
         @(negedge clk);
         chk("in_ready_after_release", in_ready, 1);
         chk("out_valid_after_release", out_valid, 0);
         chk("corr_count_held_idle", corr_count, x.cnt);
         obs_cnt = int'(corr_count);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      err_flags  = 36'd0;
      q_bus      = 108'd0;
      r_bus      = 144'd0;
      fixed_mode = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_corr_count", corr_count, 0);
      chk("rst_dec_q", dec_quotient, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // No flags: straight to DONE, data passes through untouched.
      apply(36'd0, {36{3'd2}}, {$urandom, $urandom, $urandom, $urandom, $urandom});
      drain(0);

      // Single flag at cell 7 with a constant decoder output of 5.
      apply(36'd1 << 7, {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom, $urandom});
      drain(1);
      chk("single_flag_out_valid_cycles", lat + 1, 2);

      // Two flags on a diagonal: intersection adds cells 1 and 6.
      fixed_mode = 1'b0;
      apply((36'd1 << 0) | (36'd1 << 7), {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom, $urandom});
      drain(0);
`ifdef AN_SCHED_DIRECT_EN
      chk("diag_corr_count", obs_cnt, 2);
`else
      chk("diag_corr_count", obs_cnt, 4);
`endif

      // Every cell flagged, output back-pressured for five cycles.
      apply(36'hF_FFFF_FFFF, {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom, $urandom});
      drain(5);
      chk("full_corr_count", obs_cnt, 36);

      // Reset asserted during the third SCAN cycle of a full block.
      apply(36'hF_FFFF_FFFF, {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom, $urandom});
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         scan_cell();
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midscan_rst_in_ready", in_ready, 1);
      chk("midscan_rst_out_valid", out_valid, 0);
      chk("midscan_rst_out_data", out_data, 0);
      chk("midscan_rst_corr_count", corr_count, 0);
      chk("midscan_rst_dec_q", dec_quotient, 0);
      chk("midscan_rst_dec_r", dec_residue, 0);
      cell_q.delete();
      exp_q.delete();

      // Recovery and a few random blocks.
      for (int t = 0; t < 4; t++) begin
         apply({$urandom_range(15, 0), $urandom} & {4'hF, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom, $urandom});
         drain(t);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/an_sched_6x6.md
AN_SCHED_6X6 -- requirements
Module: an_sched_6x6

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be synchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 in_valid  in  1  a 6x6 block of Barrett results is presented.
REQ-005 in_ready  out  1  the block can accept a new 6x6 block.
REQ-006 err_flags  in  36  per-cell Barrett error flag; bit k = cell k, where row = k/6 and col = k%6.
REQ-007 q_bus  in  108  per-cell quotient; cell k at bits [3k+2:3k].
REQ-008 r_bus  in  144  per-cell residue; cell k at bits [4k+3:4k].
REQ-009 dec_quotient  out  3  quotient driven to the shared an_decoder_n13.
REQ-010 dec_residue  out  4  residue driven to the shared an_decoder_n13.
REQ-011 dec_message  in  3  combinational message returned by an_decoder_n13.
REQ-012 out_valid  out  1  a corrected block is available.
REQ-013 out_ready  in  1  the consumer accepts the corrected block.
REQ-014 out_data  out  108  corrected messages, using the same packing as q_bus.
REQ-015 corr_count  out  6  number of cells replaced by decoder output in the current block.

Function
REQ-016 The state machine SHALL have three states: IDLE, SCAN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 An input handshake SHALL occur when in_valid & in_ready; on that edge the block SHALL capture q_bus, r_bus and the candidate mask.
REQ-019 Candidate mask: bit k = Er[row] & Ec[col]. Er[i] = OR of err_flags over row i. Ec[j] = OR of err_flags over col j.
REQ-020 At the handshake the next state SHALL be SCAN if the candidate mask is nonzero, otherwise DONE.
REQ-021 In SCAN, each cycle the block SHALL select the lowest-index set candidate bit s.
REQ-022 In SCAN, dec_quotient and dec_residue SHALL be driven combinationally from the captured q and r of cell s.
REQ-023 On the next edge in SCAN, the block SHALL write dec_message into captured q slot s, clear candidate bit s, and increment corr_count.
REQ-024 SCAN SHALL go to DONE on the edge that clears the last candidate bit.
REQ-025 Latency: out_valid SHALL rise k+1 cycles after the accept cycle, where k = number of candidates (range 0..36).
REQ-026 Throughput SHALL be exactly one decoder use per cycle; no cell SHALL be decoded twice.
REQ-027 Outside SCAN, dec_quotient and dec_residue SHALL be 0.
REQ-028 In DONE, out_valid SHALL be 1. out_data and corr_count SHALL remain stable until out_ready.
REQ-029 DONE with out_ready=1 SHALL go to IDLE on the next edge.
REQ-030 in_valid SHALL be ignored in SCAN and DONE; input and output handshakes SHALL never overlap.
REQ-031 corr_count SHALL hold its value from DONE through IDLE and SHALL clear at the next input handshake.
REQ-032 All 36 candidates set SHALL take 36 SCAN cycles, and corr_count SHALL equal 36 without overflow.

Reset
REQ-033 rst_n=0 on any edge SHALL force IDLE, including mid-SCAN. The partially corrected block SHALL be discarded.
REQ-034 Reset values SHALL be: in_ready=1 (from the first post-reset cycle), out_valid=0, out_data=0, corr_count=0, dec_quotient=0, dec_residue=0, candidate mask=0.

Configuration
REQ-035 With AN_SCHED_DIRECT_EN defined, the candidate mask SHALL equal err_flags directly (no row/column intersection), so only flagged cells are decoded.
REQ-036 Without AN_SCHED_DIRECT_EN, the row-by-column intersection rule in REQ-019 SHALL apply.

Structure
REQ-037 Package an_sched_pkg SHALL hold: GRID=6, N_CELLS=36, Q_W=3, R_W=4, the state enum, and the cell-index to row/col constants.
REQ-038 A sub-module an_sched_pick SHALL be used: a 36-bit lowest-set-bit priority encoder producing a 6-bit index and an any-set output.

Verification
REQ-039 No errors, q_bus all 3'd2 -> DONE the cycle after accept, out_data == q_bus, corr_count=0, dec_quotient/dec_residue stay 0.
REQ-040 err_flags bit 7 only, dec_message forced to 3'd5 -> one SCAN cycle driving cell 7's q/r; out_data slot 7 = 5, other slots unchanged; corr_count=1; out_valid two cycles after accept.
REQ-041 err_flags bits 0 and 7, default build -> cells 0, 1, 6, 7 decoded in that order over 4 cycles, corr_count=4.
REQ-042 Same stimulus as REQ-041 with AN_SCHED_DIRECT_EN -> cells 0 and 7 only, corr_count=2.
REQ-043 All 36 flags set -> 36 SCAN cycles, corr_count=36; out_valid held for 5 cycles with out_ready=0, then released; in_ready=1 the cycle after release.
REQ-044 rst_n=0 on the 3rd SCAN cycle of the REQ-043 run -> IDLE next cycle, all outputs at reset values, and the next block processes correctly.
